// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the frame controller slice: the controller state
// encoding, default frame geometry, and the layout of the packed render
// configuration word (zoom and centre coordinates).
// -----------------------------------------------------------------------------
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Default frame geometry.
  localparam int DEF_LINES   = 480;
  localparam int X_SIZE      = 640;
  localparam int Y_SIZE      = 480;

  // Downstream pixel slots (FIFO depth + pipeline stages).
  localparam int DEF_CREDITS = 16;

  // Render configuration word: {centre_y, centre_x, zoom}.
  localparam int DEF_CFG_W   = 48;
  localparam int CFG_ZOOM_LSB = 0;
  localparam int CFG_ZOOM_W   = 16;
  localparam int CFG_CX_LSB   = 16;
  localparam int CFG_CX_W     = 16;
  localparam int CFG_CY_LSB   = 32;
  localparam int CFG_CY_W     = 16;

endpackage

// File: rtl/frame_ctrl_credit.sv
// -----------------------------------------------------------------------------
// credit_counter
// Up/down counter of free downstream pixel slots. Starts full (CREDITS),
// decrements on every accepted pixel and increments on every pixel popped
// downstream. A pop while already full is a protocol error: it is ignored
// and recorded in a sticky error flag that only reset clears.
//
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   dec          one pixel accepted from the generator
//   inc          one pixel consumed downstream
//   credits      free slots, 0..CREDITS
//   empty        credits == 0
//   full         credits == CREDITS
//   err          sticky: inc seen while full
// -----------------------------------------------------------------------------
module credit_counter
  import frame_pkg::*;
#(
  parameter int CREDITS = DEF_CREDITS,
  localparam int CW     = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] credits,
  output logic          empty,
  output logic          full,
  output logic          err
);

  localparam logic [CW-1:0] FULL_VAL = CW'(CREDITS);

  logic [CW-1:0] credits_q, credits_d;
  logic          err_q, err_d;
  logic          inc_eff, dec_eff;

  always_comb begin
    // A pop at full returns no credit; a take at zero cannot happen because
    // ready is gated on credits, but it is guarded anyway.
    inc_eff   = inc && (credits_q != FULL_VAL);
    dec_eff   = dec && (credits_q != '0);
    err_d     = err_q | (inc && (credits_q == FULL_VAL));
    credits_d = credits_q;
    if (inc_eff && !dec_eff) begin
      credits_d = credits_q + CW'(1);
    end else if (dec_eff && !inc_eff) begin
      credits_d = credits_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      credits_q <= FULL_VAL;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign credits = credits_q;
  assign empty   = (credits_q == '0);
  assign full    = (credits_q == FULL_VAL);
  assign err     = err_q;

endmodule

// File: rtl/frame_ctrl.sv
// -----------------------------------------------------------------------------
// frame_ctrl
// Frame-level sequencer for the pixel coordinate generator and the render
// pipeline behind it. Gates generator ready with downstream credits so no
// pixel is dropped, commits the render configuration only at frame start,
// and counts lines and frames. Single-shot (start) or back-to-back
// (continuous) operation.
//
// Optional build macro: FRAME_CTRL_STATS_EN enables the backpressure stall
// counter on stall_cycles; without it stall_cycles is tied to zero.
//
// Ports:
//   clk, resetn    clock, asynchronous active-low reset (shared with generator
//                  and downstream FIFO)
//   start          pulse, request one frame (only honoured in IDLE)
//   continuous     level, run frames back-to-back
//   cfg_we/data    write the configuration shadow register
//   coord_valid    generator valid
//   coord_lastx    generator end-of-line flag
//   coord_ready    ready to the generator (no combinational path from valid)
//   out_pop        downstream consumed one pixel
//   cfg_active     configuration in force for the current frame
//   busy           controller not IDLE
//   frame_done     one-cycle pulse when a frame has fully drained
//   line_count     lines completed in the current frame
//   frame_count    frames completed (wraps)
//   credit_err     sticky pop-while-full error
//   stall_cycles   backpressure stall cycles in the current frame
// -----------------------------------------------------------------------------
module frame_ctrl
  import frame_pkg::*;
#(
  parameter int LINES   = DEF_LINES,
  parameter int CREDITS = DEF_CREDITS,
  parameter int CFG_W   = DEF_CFG_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             continuous,
  input  logic             cfg_we,
  input  logic [CFG_W-1:0] cfg_data,
  input  logic             coord_valid,
  input  logic             coord_lastx,
  output logic             coord_ready,
  input  logic             out_pop,
  output logic [CFG_W-1:0] cfg_active,
  output logic             busy,
  output logic             frame_done,
  output logic [8:0]       line_count,
  output logic [15:0]      frame_count,
  output logic             credit_err,
  output logic [31:0]      stall_cycles
);

  localparam int         CW        = $clog2(CREDITS + 1);
  localparam logic [8:0] LAST_LINE = 9'(LINES - 1);

  state_e           state_q, state_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] cfg_active_q, cfg_active_d;
  logic [8:0]       line_count_q, line_count_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             line_wrap_q, line_wrap_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;

  logic [CW-1:0]    credits;
  logic             cred_empty, cred_full;
  logic             hs;

  credit_counter #(
    .CREDITS (CREDITS)
  ) u_credits (
    .clk     (clk),
    .resetn  (resetn),
    .dec     (hs),
    .inc     (out_pop),
    .credits (credits),
    .empty   (cred_empty),
    .full    (cred_full),
    .err     (credit_err)
  );

  // Ready depends only on registered state; line_wrap blocks the cycle right
  // after the final handshake of a frame.
  assign coord_ready = (state_q == RUN) && !cred_empty && !line_wrap_q;
  assign hs          = coord_valid && coord_ready;

  always_comb begin
    state_d       = state_q;
    shadow_d      = cfg_we ? cfg_data : shadow_q;
    cfg_active_d  = cfg_active_q;
    line_count_d  = line_count_q;
    frame_count_d = frame_count_q;
    line_wrap_d   = 1'b0;
    frame_done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start || continuous) state_d = LOAD;
      end
      LOAD: begin
        // shadow_d already carries a same-cycle cfg_we write.
        cfg_active_d = shadow_d;
        line_count_d = '0;
        state_d      = RUN;
      end
      RUN: begin
        if (hs && coord_lastx) begin
          line_count_d = line_count_q + 9'd1;
          if (line_count_q == LAST_LINE) begin
            line_wrap_d = 1'b1;
            state_d     = DRAIN;
          end
        end
      end
      DRAIN: begin
        // All credits back means every pixel has left the pipeline.
        if (cred_full) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = continuous ? LOAD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      cfg_active_q  <= '0;
      line_count_q  <= '0;
      frame_count_q <= '0;
      line_wrap_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      cfg_active_q  <= cfg_active_d;
      line_count_q  <= line_count_d;
      frame_count_q <= frame_count_d;
      line_wrap_q   <= line_wrap_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
    end
  end

  assign cfg_active  = cfg_active_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign line_count  = line_count_q;
  assign frame_count = frame_count_q;

`ifdef FRAME_CTRL_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == LOAD) begin
      stall_d = '0;
    end else if ((state_q == RUN) && coord_valid && cred_empty &&
                 (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_ctrl
// Directed bench for frame_ctrl with LINES=3, CREDITS=4 and an 8-pixel-per-
// line generator model. Line and frame completions are predicted from the
// bench's own handshake model into queues and compared when the DUT reports.
// -----------------------------------------------------------------------------
module tb_frame_ctrl;

  localparam int LINES   = 3;
  localparam int CREDITS = 4;
  localparam int CFG_W   = 48;
  localparam int XPX     = 8;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic             continuous = 1'b0;
  logic             cfg_we = 1'b0;
  logic [CFG_W-1:0] cfg_data = '0;
  logic             coord_valid = 1'b0;
  logic             coord_lastx = 1'b0;
  logic             out_pop = 1'b0;
  logic             coord_ready;
  logic [CFG_W-1:0] cfg_active;
  logic             busy;
  logic             frame_done;
  logic [8:0]       line_count;
  logic [15:0]      frame_count;
  logic             credit_err;
  logic [31:0]      stall_cycles;

  frame_ctrl #(
    .LINES   (LINES),
    .CREDITS (CREDITS),
    .CFG_W   (CFG_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .continuous   (continuous),
    .cfg_we       (cfg_we),
    .cfg_data     (cfg_data),
    .coord_valid  (coord_valid),
    .coord_lastx  (coord_lastx),
    .coord_ready  (coord_ready),
    .out_pop      (out_pop),
    .cfg_active   (cfg_active),
    .busy         (busy),
    .frame_done   (frame_done),
    .line_count   (line_count),
    .frame_count  (frame_count),
    .credit_err   (credit_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bench model state
  int  hs_total = 0;
  int  line_m = 0;
  int  x_m = 0;
  int  frames_m = 0;
  int  m_cr = CREDITS;
  int  fd_seen = 0;
  int  cyc = 0;
  int  last_hs_cyc = -1;
  int  stall_m = 0;
  bit  pop_en = 1'b1;
  bit  gap_mode = 1'b0;
  logic [8:0]  lc_q[$];
  logic [15:0] fc_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict this cycle's handshake/pop, advance, then compare.
  task automatic tick();
    logic hs, lx, pop;
    hs  = coord_valid && coord_ready;
    lx  = coord_lastx;
    pop = out_pop;
    @(posedge clk);
    #1;
    cyc++;
    m_cr = m_cr - (hs ? 1 : 0) + ((pop && m_cr != CREDITS) ? 1 : 0);
    if (hs) begin
      hs_total++;
      if (gap_mode && line_m == 0 && x_m == 0 && last_hs_cyc >= 0)
        check("frame_gap_ge3", 64'(cyc - last_hs_cyc >= 3), 64'd1);
      last_hs_cyc = cyc;
      if (lx) begin
        line_m++;
        lc_q.push_back(9'(line_m));
        x_m = 0;
        if (line_m == LINES) begin
          frames_m++;
          fc_q.push_back(16'(frames_m));
          line_m = 0;
        end
      end else begin
        x_m++;
      end
    end
    coord_lastx = (x_m == XPX - 1);
    if (pop_en) out_pop = (m_cr < CREDITS);
    if (lc_q.size() != 0) check("line_count", 64'(line_count), 64'(lc_q.pop_front()));
    if (frame_done) begin
      fd_seen++;
      if (fc_q.size() == 0) check("frame_done_spurious", 64'(frame_done), 64'd0);
      else check("frame_count", 64'(frame_count), 64'(fc_q.pop_front()));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int f0;
    int n;
    f0 = fd_seen;
    n  = 0;
    while (fd_seen == f0 && n < budget) begin
      tick();
      n++;
    end
    check("frame_done_seen", 64'(fd_seen - f0), 64'd1);
  endtask

  initial begin
    int h0;
    int n;

    // Reset state
    repeat (3) tick();
    check("rst_ready", 64'(coord_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_credit_err", 64'(credit_err), 64'd0);
    check("rst_line_count", 64'(line_count), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_stall", 64'(stall_cycles), 64'd0);
    check("rst_cfg_active", 64'(cfg_active), 64'd0);
    check("rst_credits", 64'(dut.credits), 64'd4);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    coord_valid = 1'b1;

    // Single frame with downstream popping whenever it holds a pixel
    hs_total = 0;
    pulse_start();
    check("ready_in_load", 64'(coord_ready), 64'd0);
    check("busy_in_load", 64'(busy), 64'd1);
    tick();
    check("ready_after_load", 64'(coord_ready), 64'd1);
    run_until_done(200);
    tick();
    tick();
    check("f1_handshakes", 64'(hs_total), 64'd24);
    check("f1_done_pulses", 64'(fd_seen), 64'd1);
    check("f1_frame_count", 64'(frame_count), 64'd1);
    check("f1_idle", 64'(busy), 64'd0);
    check("f1_line_hold", 64'(line_count), 64'd3);
    check("f1_credits", 64'(dut.credits), 64'd4);
    check("f1_credit_err", 64'(credit_err), 64'd0);

    // Backpressure: no pops
    pop_en  = 1'b0;
    out_pop = 1'b0;
    h0      = hs_total;
    stall_m = 0;
    pulse_start();
    repeat (20) begin
      if (m_cr == 0 && coord_valid) stall_m++;
      tick();
    end
    check("bp_handshakes", 64'(hs_total - h0), 64'd4);
    check("bp_ready_low", 64'(coord_ready), 64'd0);
    check("bp_credits", 64'(dut.credits), 64'd0);
`ifdef FRAME_CTRL_STATS_EN
    check("bp_stall_cycles", 64'(stall_cycles), 64'(stall_m));
`else
    check("bp_stall_cycles", 64'(stall_cycles), 64'd0);
`endif
    out_pop = 1'b1;
    tick();
    out_pop = 1'b0;
    repeat (10) tick();
    check("bp_one_more", 64'(hs_total - h0), 64'd5);
    check("bp_ready_low2", 64'(coord_ready), 64'd0);
    pop_en  = 1'b1;
    out_pop = (m_cr < CREDITS);
    run_until_done(200);
    tick();
    check("bp_frame_hs", 64'(hs_total - h0), 64'd24);
    check("bp_frame_count", 64'(frame_count), 64'd2);

    // Configuration commit only at LOAD
    pulse_start();
    repeat (4) tick();
    cfg_we   = 1'b1;
    cfg_data = 48'h123;
    tick();
    cfg_we = 1'b0;
    check("cfg_hold_in_run", 64'(cfg_active), 64'd0);
    run_until_done(200);
    tick();
    check("cfg_hold_after_frame", 64'(cfg_active), 64'd0);
    pulse_start();
    tick();
    check("cfg_commit", 64'(cfg_active), 64'h123);
    run_until_done(200);
    tick();
    start = 1'b1;
    tick();
    start    = 1'b0;
    cfg_we   = 1'b1;
    cfg_data = 48'h456;
    tick();
    cfg_we = 1'b0;
    check("cfg_load_bypass", 64'(cfg_active), 64'h456);
    run_until_done(200);
    tick();
    check("cfg_frame_count", 64'(frame_count), 64'd5);

    // Continuous mode, cleared during the third frame
    gap_mode   = 1'b1;
    h0         = hs_total;
    continuous = 1'b1;
    run_until_done(200);
    run_until_done(200);
    repeat (10) tick();
    continuous = 1'b0;
    run_until_done(200);
    repeat (3) tick();
    gap_mode = 1'b0;
    check("cont_frame_count", 64'(frame_count), 64'd8);
    check("cont_idle", 64'(busy), 64'd0);
    check("cont_handshakes", 64'(hs_total - h0), 64'd72);
    check("cont_ready_low", 64'(coord_ready), 64'd0);

    // Pop while full, then simultaneous handshake and pop
    pop_en  = 1'b0;
    out_pop = 1'b1;
    tick();
    out_pop = 1'b0;
    check("err_set", 64'(credit_err), 64'd1);
    check("err_credits_full", 64'(dut.credits), 64'd4);
    h0 = hs_total;
    pulse_start();
    n = 0;
    while (hs_total - h0 < 2 && n < 20) begin
      tick();
      n++;
    end
    check("sim_pre_credits", 64'(dut.credits), 64'd2);
    out_pop = 1'b1;
    tick();
    out_pop = 1'b0;
    check("sim_hs_taken", 64'(hs_total - h0), 64'd3);
    check("sim_credits_same", 64'(dut.credits), 64'd2);
    check("err_sticky", 64'(credit_err), 64'd1);

    // Asynchronous reset in the middle of line 2
    pop_en  = 1'b1;
    out_pop = (m_cr < CREDITS);
    n = 0;
    while (!(line_m == 1 && x_m >= 3) && n < 100) begin
      tick();
      n++;
    end
    check("reached_line2", 64'(line_m == 1 && x_m >= 3), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_ready", 64'(coord_ready), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_credits", 64'(dut.credits), 64'd4);
    check("ar_line_count", 64'(line_count), 64'd0);
    check("ar_frame_count", 64'(frame_count), 64'd0);
    check("ar_credit_err", 64'(credit_err), 64'd0);
    check("ar_cfg_active", 64'(cfg_active), 64'd0);
    lc_q.delete();
    fc_q.delete();
    line_m      = 0;
    x_m         = 0;
    frames_m    = 0;
    m_cr        = CREDITS;
    out_pop     = 1'b0;
    coord_lastx = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    hs_total = 0;
    pulse_start();
    run_until_done(200);
    tick();
    check("post_rst_handshakes", 64'(hs_total), 64'd24);
    check("post_rst_frame_count", 64'(frame_count), 64'd1);
    check("post_rst_idle", 64'(busy), 64'd0);
    check("post_rst_line_hold", 64'(line_count), 64'd3);
    check("post_rst_credit_err", 64'(credit_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
